// File: rtl/load_store_unit.sv
// Load/store unit: sole master of data_memory; byte/half/word access with sub-word RMW.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module load_store_unit #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_fault,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e            state_q, state_d;
   logic              we_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       word_q;
   logic [31:0]       rdata_q;
   logic              fault_q;

   logic              accept;
   logic              out_of_range;
   logic              fault_d;
   logic [ADDR_W-1:0] addr_acc;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_ext;
   logic [31:0]       merged;

   assign req_ready = (state_q == StIdle);
   assign accept    = req_valid && req_ready;

   assign out_of_range = (req_addr >> 2) >= ADDR_W'(MEM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   assign fault_d    = (req_size == 2'b11) || out_of_range || misaligned;
   assign addr_acc   = req_addr;
`else
   assign fault_d = (req_size == 2'b11) || out_of_range;
   // Misaligned accesses are silently rounded down to the natural boundary.
   always_comb begin
      addr_acc = req_addr;
      if (req_size == 2'b01) addr_acc[0] = 1'b0;
      if (req_size == 2'b10) addr_acc[1:0] = 2'b00;
   end
`endif

   // Load extraction works on the live read data so the result is ready at the end of READ.
   assign lane_b = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
   assign lane_h = mem_read_data[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      unique case (size_q)
         2'b00:   load_ext = {{24{~unsigned_q & lane_b[7]}}, lane_b};
         2'b01:   load_ext = {{16{~unsigned_q & lane_h[15]}}, lane_h};
         default: load_ext = mem_read_data;
      endcase
   end

   always_comb begin
      merged = word_q;
      unique case (size_q)
         2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (fault_d)                             state_d = StResp;
               else if (req_we && req_size == 2'b10)    state_d = StWrite;
               else                                     state_d = StRead;
            end
         end
         StRead:  state_d = we_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  if (resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         word_q     <= '0;
         rdata_q    <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= addr_acc;
            wdata_q    <= req_wdata;
            fault_q    <= fault_d;
            rdata_q    <= '0;
         end
         if (state_q == StRead) begin
            word_q <= mem_read_data;
            if (!we_q) rdata_q <= load_ext;
         end
      end
   end

   assign MemRead        = (state_q == StRead);
   assign MemWrite       = (state_q == StWrite);
   assign mem_address    = (MemRead || MemWrite) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;
   assign mem_write_data = MemWrite ? merged : 32'h0;

   assign resp_valid = (state_q == StResp);
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;
   assign resp_fault = resp_valid && fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan items plus randomized traffic
// checked against a byte-level memory model; honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;
   localparam int unsigned AW = 32;
   localparam int unsigned NW = 64;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_unsigned = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [31:0]   resp_rdata;
   logic          resp_fault;
   logic          MemRead;
   logic          MemWrite;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned cyc = 0;

   logic [31:0] dmem    [NW];
   logic [31:0] ref_mem [NW];

   load_store_unit #(.ADDR_W(AW), .MEM_WORDS(NW)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .MemRead        (MemRead),
      .MemWrite       (MemWrite),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // data_memory: combinational read, write committed on the rising edge
   assign mem_read_data = (MemRead && mem_address < NW) ? dmem[mem_address[5:0]] : 32'h0;
   always @(posedge clk) if (MemWrite && mem_address < NW) dmem[mem_address[5:0]] <= mem_write_data;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h cyc=%0d", name, got, want, cyc);
      end
   endtask

   typedef struct {
      logic        fault;
      logic [31:0] rdata;
      int          lat;
      int          nrd;
      int          nwr;
      int          idx;
      logic [31:0] nword;
   } exp_t;

   // Reference: treat the word as four bytes selected by a shift/mask.
   function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata);
      exp_t        e;
      logic [31:0] a, w, v, mask;
      int          sh;
      logic        mis;
      a = addr;
      mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
      if (!TRAP && size == 2'd1) a[0] = 1'b0;
      if (!TRAP && size == 2'd2) a[1:0] = 2'd0;
      e.fault = (size == 2'd3) || ((addr >> 2) >= NW) || (TRAP && mis);
      e.idx   = int'(a >> 2);
      e.rdata = 32'h0;
      e.nword = 32'h0;
      e.nrd   = 0;
      e.nwr   = 0;
      e.lat   = 1;
      if (e.fault) return e;
      w  = ref_mem[e.idx];
      sh = int'(a[1:0]) * 8;
      if (!we) begin
         e.nrd = 1;
         e.lat = 2;
         v = w >> sh;
         if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
         end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
         end
         e.rdata = v;
      end else begin
         mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
         mask = mask << sh;
         e.nword = (w & ~mask) | ((wdata << sh) & mask);
         e.nwr = 1;
         e.nrd = (size == 2'd2) ? 0 : 1;
         e.lat = (size == 2'd2) ? 2 : 3;
      end
      return e;
   endfunction

   // Compare process: checks every cycle against the model entry of the in-flight request.
   exp_t        cur;
   logic        busy = 1'b0;
   logic        seen = 1'b0;
   int          acc_edge = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          rd_pulses = 0;
   int          wr_pulses = 0;
   logic [31:0] last_wdata = '0;
   logic [31:0] last_waddr = '0;

   always @(negedge clk) begin
      if (reset) begin
         busy = 1'b0;
         seen = 1'b0;
      end else begin
         check("strobe_excl", 32'(MemRead & MemWrite), 32'h0);
         if (MemRead)  rd_pulses++;
         if (MemWrite) wr_pulses++;
         if (busy) begin
            check("req_ready_busy", 32'(req_ready), 32'h0);
            if (MemRead) begin
               rd_cnt++;
               check("rd_addr", mem_address, 32'(cur.idx));
            end
            if (MemWrite) begin
               wr_cnt++;
               last_wdata = mem_write_data;
               last_waddr = mem_address;
               check("wr_addr", mem_address, 32'(cur.idx));
               check("wr_data", mem_write_data, cur.nword);
            end
            if (resp_valid) begin
               if (!seen) begin
                  seen = 1'b1;
                  check("latency", 32'(int'(cyc) - acc_edge + 1), 32'(cur.lat));
               end
               check("resp_rdata", resp_rdata, cur.rdata);
               check("resp_fault", 32'(resp_fault), 32'(cur.fault));
               if (resp_ready) begin
                  check("n_read", 32'(rd_cnt), 32'(cur.nrd));
                  check("n_write", 32'(wr_cnt), 32'(cur.nwr));
                  if (cur.nwr != 0) ref_mem[cur.idx] = cur.nword;
                  busy = 1'b0;
               end
            end
         end else begin
            check("idle_quiet", {29'h0, MemRead, MemWrite, resp_valid}, 32'h0);
            check("req_ready_idle", 32'(req_ready), 32'h1);
            if (req_valid && req_ready) begin
               cur      = model(req_we, req_size, req_unsigned, req_addr, req_wdata);
               busy     = 1'b1;
               seen     = 1'b0;
               acc_edge = int'(cyc) + 1;
               rd_cnt   = 0;
               wr_cnt   = 0;
            end
         end
      end
   end

   logic [31:0] got_rdata;
   logic        got_fault;
   int          got_lat;

   // Caller sits #1 after a rising edge; returns #1 after the response handshake edge.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall);
      int n;
      int left;
      int edges;
      req_valid = 1'b1;
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      resp_ready = 1'b0;
      got_rdata = 32'hX;
      got_fault = 1'bX;
      got_lat = 0;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL req_timeout: req_ready=%b want 1", req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 1;
      left = stall;
      while (edges < 40) begin
         if (resp_valid) begin
            if (got_lat == 0) got_lat = edges;
            if (left == 0) begin
               got_rdata = resp_rdata;
               got_fault = resp_fault;
               resp_ready = 1'b1;
               @(posedge clk); #1;
               resp_ready = 1'b0;
               return;
            end
            left--;
         end
         @(posedge clk); #1;
         edges++;
      end
      total++; bad++;
      $display("FAIL resp_timeout: resp_valid=%b want 1", resp_valid);
   endtask

   logic [31:0] v;
   logic [31:0] exp5;
   int          pulses0;

   initial begin
      for (int i = 0; i < int'(NW); i++) begin
         v = $urandom;
         dmem[i] = v;
         ref_mem[i] = v;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h1);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_fault", 32'(resp_fault), 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      reset = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF, 0);
      check("sw_lat", 32'(got_lat), 32'd2);
      check("sw_waddr", last_waddr, 32'd5);
      check("sw_wdata", last_wdata, 32'hDEAD_BEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
      check("lw_rdata", got_rdata, 32'hDEAD_BEEF);
      check("lw_lat", 32'(got_lat), 32'd2);
      do_req(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00AA, 0);
      check("sb_wdata", last_wdata, 32'hDEAD_AAEF);
      check("sb_lat", 32'(got_lat), 32'd3);
      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
      check("lw_after_sb", got_rdata, 32'hDEAD_AAEF);
      do_req(1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 0);
      check("lb_signed", got_rdata, 32'hFFFF_FFAA);
      do_req(1'b0, 2'd0, 1'b1, 32'h15, 32'h0, 0);
      check("lb_unsigned", got_rdata, 32'h0000_00AA);
      do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 0);
      check("lh_signed", got_rdata, 32'hFFFF_DEAD);
      do_req(1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 0);
      check("lh_unsigned", got_rdata, 32'h0000_DEAD);

      pulses0 = wr_pulses;
      do_req(1'b1, 2'd1, 1'b0, 32'h17, 32'h0000_1234, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("mis_fault", 32'(got_fault), 32'h1);
      check("mis_lat", 32'(got_lat), 32'd1);
      check("mis_no_write", 32'(wr_pulses - pulses0), 32'd0);
      exp5 = 32'hDEAD_AAEF;
`else
      check("mis_fault", 32'(got_fault), 32'h0);
      check("mis_wdata", last_wdata, 32'h1234_AAEF);
      exp5 = 32'h1234_AAEF;
`endif
      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
      check("word5_after_mis", got_rdata, exp5);

      pulses0 = rd_pulses;
      do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0);
      check("oor_fault", 32'(got_fault), 32'h1);
      check("oor_rdata", got_rdata, 32'h0);
      check("oor_lat", 32'(got_lat), 32'd1);
      check("oor_no_read", 32'(rd_pulses - pulses0), 32'd0);
      do_req(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0);
      check("size3_fault", 32'(got_fault), 32'h1);

      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 3);
      check("stall_rdata", got_rdata, exp5);
      check("stall_lat", 32'(got_lat), 32'd2);

      // Reset while a byte store sits in READ: the write must never happen.
      pulses0 = wr_pulses;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'd0;
      req_unsigned = 1'b0;
      req_addr = 32'h15;
      req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_in_read", 32'(MemRead), 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_req_ready", 32'(req_ready), 32'h1);
      check("mid_resp_valid", 32'(resp_valid), 32'h0);
      @(posedge clk); #1;
      check("mid_no_write", 32'(wr_pulses - pulses0), 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
      check("mid_word5", got_rdata, exp5);

      for (int i = 0; i < 300; i++) begin
         logic        we;
         logic [1:0]  size;
         logic [31:0] addr;
         int          r;
         we = 1'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         addr = $urandom_range(0, NW * 4 - 1);
         if ($urandom_range(0, 15) == 0) addr = addr + NW * 4;
         do_req(we, size, 1'($urandom_range(0, 1)), addr, $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      @(posedge clk); #1;
      for (int i = 0; i < int'(NW); i++) check("final_mem", dmem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
